clock_divider_multi: RTL

Multi-channel, runtime-programmable clock divider. Each channel derives a divided clock from one source clock, with its own divisor, high time and enable. Divisor and high-time updates are shadowed and take effect only at a period boundary, so no runt pulses occur. A shared `sync` input realigns all running channels; per-channel `period_start` pulses feed downstream samplers and timers.

---
 rtl/clock_divider_multi.sv | 139 +++++++++++++
 1 files changed

// File: rtl/clock_divider_multi.sv
// clock_divider_multi: runtime-programmable multi-channel clock divider.
// Each channel has shadowed divisor/high-time updates and a shared sync realignment.
`default_nettype none

module clock_divider_multi #(
  parameter int CHANNELS        = 2,
  parameter int WIDTH           = 8,
  parameter int DEFAULT_DIVISOR = 4
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       enable,
  input  logic [CHANNELS-1:0]       load,
  input  logic [CHANNELS*WIDTH-1:0] divisor_in,
  input  logic [CHANNELS*WIDTH-1:0] high_in,
  input  logic                      sync,
  output logic [CHANNELS-1:0]       clock_divided,
  output logic [CHANNELS-1:0]       period_start,
  output logic [CHANNELS-1:0]       pending
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  localparam logic [WIDTH-1:0] RESET_D = WIDTH'(DEFAULT_DIVISOR);
  localparam logic [WIDTH-1:0] RESET_H = WIDTH'(DEFAULT_DIVISOR / 2);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] TWO     = WIDTH'(2);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    state_t           state, state_nx;
    logic [WIDTH-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] act_d, act_d_nx, act_h, act_h_nx;
    logic [WIDTH-1:0] sh_d, sh_d_nx, sh_h, sh_h_nx;
    logic             pend, pend_nx;
    logic             div_q, start_q;
    logic [WIDTH-1:0] d_eff, d_eff_nx, h_eff_nx;
    logic             wrap, boundary, running_nx;
    logic [WIDTH-1:0] d_load, h_load;

    assign d_load = divisor_in[i*WIDTH +: WIDTH];
    assign h_load = high_in[i*WIDTH +: WIDTH];

    always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      boundary = 1'b0;
      act_d_nx = act_d;
      act_h_nx = act_h;
      sh_d_nx  = sh_d;
      sh_h_nx  = sh_h;
      pend_nx  = pend;

      d_eff = (act_d < TWO) ? TWO : act_d;
      wrap  = (cnt == d_eff - ONE);

      case (state)
        IDLE: begin
          // The start edge is an application point for shadowed settings.
          if (enable[i]) begin
            state_nx = RUN;
            cnt_nx   = '0;
            boundary = 1'b1;
          end
        end
        RUN: begin
          boundary = sync || wrap;
          cnt_nx   = boundary ? '0 : cnt + ONE;
          if (!enable[i]) state_nx = STOPPING;
        end
        STOPPING: begin
          boundary = sync || wrap;
          cnt_nx   = boundary ? '0 : cnt + ONE;
          if (enable[i])     state_nx = RUN;
          else if (boundary) state_nx = IDLE;
        end
        default: begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end
      endcase

      // A load landing on a boundary bypasses the shadow entirely.
      if (boundary) begin
        if (load[i]) begin
          act_d_nx = d_load;
          act_h_nx = h_load;
          pend_nx  = 1'b0;
        end else if (pend) begin
          act_d_nx = sh_d;
          act_h_nx = sh_h;
          pend_nx  = 1'b0;
        end
      end else if (load[i]) begin
        sh_d_nx = d_load;
        sh_h_nx = h_load;
        pend_nx = 1'b1;
      end

      running_nx = (state_nx != IDLE);
      d_eff_nx   = (act_d_nx < TWO) ? TWO : act_d_nx;
      h_eff_nx   = (act_h_nx < d_eff_nx) ? act_h_nx : d_eff_nx;
    end

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        state   <= IDLE;
        cnt     <= '0;
        act_d   <= RESET_D;
        act_h   <= RESET_H;
        sh_d    <= '0;
        sh_h    <= '0;
        pend    <= 1'b0;
        div_q   <= 1'b0;
        start_q <= 1'b0;
      end else begin
        state   <= state_nx;
        cnt     <= cnt_nx;
        act_d   <= act_d_nx;
        act_h   <= act_h_nx;
        sh_d    <= sh_d_nx;
        sh_h    <= sh_h_nx;
        pend    <= pend_nx;
        div_q   <= running_nx && (cnt_nx < h_eff_nx);
        start_q <= running_nx && (cnt_nx == '0);
      end
    end

    assign clock_divided[i] = div_q;
    assign period_start[i]  = start_q;
    assign pending[i]       = pend;
  end

endmodule

`default_nettype wire
